// File: rtl/bpu_btb_ras.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit direction
// counters plus a speculative return address stack. Lookup is purely
// combinational on the fetch PC; training arrives from execute and is
// written on the clock edge, so a same-cycle lookup sees the old entry.
module bpu_btb_ras #(
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_W       = 12,
    parameter int RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_i,
    input  logic        fetch_fire,
    output logic        pred_taken,
    output logic [63:0] pred_pc,
    input  logic        upd_valid,
    input  logic [63:0] upd_pc,
    input  logic [1:0]  upd_type,
    input  logic        upd_taken,
    input  logic [63:0] upd_target,
    input  logic        bpu_clr
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] T_BRANCH = 2'b00;
    localparam logic [1:0] T_CALL   = 2'b10;
    localparam logic [1:0] T_RET    = 2'b11;

    // BTB storage: valid and counters are control state (reset/cleared),
    // tag/type/target are only meaningful while valid is set.
    logic [BTB_ENTRIES-1:0] valid;
    logic [1:0]             ctr      [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_mem  [BTB_ENTRIES];
    logic [1:0]             type_mem [BTB_ENTRIES];
    logic [63:0]            tgt_mem  [BTB_ENTRIES];

    // RAS: ras_ptr is the next free slot, ras_cnt saturates at RAS_DEPTH
    // so the oldest return address is silently overwritten on overflow.
    logic [63:0]      ras [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [CNT_W-1:0] ras_cnt;

    // Saturating 2-bit direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? 2'b11 : c + 2'b01;
        else
            return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // Lookup side
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       lk_type;
    logic             hit;
    logic             taken;
    logic             ras_empty;
    logic [63:0]      ras_top;
    logic [63:0]      seq_pc;

    assign idx       = pc_i[IDX_W+1:2];
    assign tag       = pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_type   = type_mem[idx];
    assign hit       = valid[idx] && (tag_mem[idx] == tag);
    assign taken     = hit && ((lk_type != T_BRANCH) || ctr[idx][1]);
    assign ras_empty = (ras_cnt == '0);
    assign ras_top   = ras[ras_ptr - PTR_W'(1)];
    assign seq_pc    = pc_i + 64'd4;

    // Update side
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_eff_taken;
    logic             u_write;

    assign u_idx       = upd_pc[IDX_W+1:2];
    assign u_tag       = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign u_hit       = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    assign u_eff_taken = upd_taken || (upd_type != T_BRANCH);
    // Hit-and-taken rewrites, miss-and-taken allocates: both write the payload.
    assign u_write     = upd_valid && u_eff_taken && !bpu_clr;

    // RAS movement only for fired fetches that hit a call/return entry.
    logic ras_push;
    logic ras_pop;

    assign ras_push = fetch_fire && hit && (lk_type == T_CALL) && !bpu_clr;
    assign ras_pop  = fetch_fire && hit && (lk_type == T_RET) && !ras_empty && !bpu_clr;

    // Unused PC bits (byte offset and bits above the tag).
    logic unused_bits;
    assign unused_bits = ^{pc_i[63:IDX_W+TAG_W+2], pc_i[1:0],
                           upd_pc[63:IDX_W+TAG_W+2], upd_pc[1:0]};

    // Prediction outputs, forced quiet while reset is held.
    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = 64'h0;
        if (!rst) begin
            pred_taken = taken;
            if (taken)
                pred_pc = ((lk_type == T_RET) && !ras_empty) ? ras_top : tgt_mem[idx];
            else
                pred_pc = seq_pc;
        end
    end

    // Control state: valid bits, direction counters and RAS pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid   <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++)
                ctr[i] <= 2'b01;
        end else if (bpu_clr) begin
            valid   <= '0;
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else begin
            if (u_write)
                valid[u_idx] <= 1'b1;
            if (upd_valid) begin
                if (u_hit && (upd_type == T_BRANCH))
                    ctr[u_idx] <= ctr_step(ctr[u_idx], upd_taken);
                else if (!u_hit && u_eff_taken)
                    ctr[u_idx] <= 2'b10;
            end
            if (ras_push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != CNT_W'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (ras_pop) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // Entry payload written on allocation or taken rewrite.
    always_ff @(posedge clk) begin
        if (u_write) begin
            tag_mem[u_idx]  <= u_tag;
            type_mem[u_idx] <= upd_type;
            tgt_mem[u_idx]  <= upd_target;
        end
    end

    // Return address payload written on push.
    always_ff @(posedge clk) begin
        if (ras_push)
            ras[ras_ptr] <= seq_pc;
    end

endmodule

// File: tb/tb_bpu_btb_ras.sv
// Testbench for bpu_btb_ras: directed scenarios followed by random traffic,
// every cycle cross-checked against a behavioural model built from arrays
// and a queue-based return stack.
module tb_bpu_btb_ras;

    localparam int BTB_ENTRIES = 64;
    localparam int TAG_W       = 12;
    localparam int RAS_DEPTH   = 8;
    localparam int IDX_W       = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_i;
    logic        fetch_fire;
    logic        pred_taken;
    logic [63:0] pred_pc;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic [1:0]  upd_type;
    logic        upd_taken;
    logic [63:0] upd_target;
    logic        bpu_clr;

    bpu_btb_ras #(
        .BTB_ENTRIES(BTB_ENTRIES),
        .TAG_W      (TAG_W),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .fetch_fire(fetch_fire),
        .pred_taken(pred_taken),
        .pred_pc   (pred_pc),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_type  (upd_type),
        .upd_taken (upd_taken),
        .upd_target(upd_target),
        .bpu_clr   (bpu_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_valid [BTB_ENTRIES];
    logic [63:0] m_tag   [BTB_ENTRIES];
    int          m_type  [BTB_ENTRIES];
    int          m_ctr   [BTB_ENTRIES];
    logic [63:0] m_tgt   [BTB_ENTRIES];
    logic [63:0] ras_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % BTB_ENTRIES);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] pc);
        return (pc >> (IDX_W + 2)) % (64'd1 << TAG_W);
    endfunction

    task automatic model_reset();
        foreach (m_valid[j]) begin
            m_valid[j] = 1'b0;
            m_ctr[j]   = 1;
        end
        ras_q.delete();
    endtask

    function automatic void m_lookup(input logic [63:0] pc, output bit hit,
                                     output bit tk, output logic [63:0] ppc);
        int i;
        i   = idx_of(pc);
        hit = m_valid[i] && (m_tag[i] == tag_of(pc));
        tk  = hit && ((m_type[i] != 0) || (m_ctr[i] >= 2));
        if (!tk)
            ppc = pc + 64'd4;
        else if (m_type[i] == 3 && ras_q.size() > 0)
            ppc = ras_q[$];
        else
            ppc = m_tgt[i];
    endfunction

    task automatic model_tick();
        bit h, tk, eff, uh;
        logic [63:0] pp;
        int i;
        if (rst) begin
            model_reset();
        end else if (bpu_clr) begin
            foreach (m_valid[j]) m_valid[j] = 1'b0;
            ras_q.delete();
        end else begin
            m_lookup(pc_i, h, tk, pp);
            i = idx_of(pc_i);
            if (fetch_fire && h) begin
                if (m_type[i] == 2) begin
                    if (ras_q.size() == RAS_DEPTH) void'(ras_q.pop_front());
                    ras_q.push_back(pc_i + 64'd4);
                end else if (m_type[i] == 3 && ras_q.size() > 0) begin
                    void'(ras_q.pop_back());
                end
            end
            if (upd_valid) begin
                i   = idx_of(upd_pc);
                eff = (upd_type != 2'b00) || upd_taken;
                uh  = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
                if (uh) begin
                    if (upd_type == 2'b00)
                        m_ctr[i] = upd_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                             : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (eff) begin
                        m_tgt[i]  = upd_target;
                        m_type[i] = int'(upd_type);
                    end
                end else if (eff) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = tag_of(upd_pc);
                    m_type[i]  = int'(upd_type);
                    m_tgt[i]   = upd_target;
                    m_ctr[i]   = 2;
                end
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic set_in(input logic [63:0] pc, input bit ff, input bit uv,
                          input logic [63:0] upc, input logic [1:0] ut, input bit utk,
                          input logic [63:0] utgt, input bit clr);
        pc_i       = pc;
        fetch_fire = ff;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_type   = ut;
        upd_taken  = utk;
        upd_target = utgt;
        bpu_clr    = clr;
    endtask

    // Called at a negedge with inputs set; checks mid-cycle, advances one clock.
    task automatic cycle(input string name, input bit chk, input bit etk, input logic [63:0] epc);
        bit h, tk;
        logic [63:0] pp;
        #1;
        if (rst) begin
            tk = 1'b0;
            pp = 64'h0;
        end else begin
            m_lookup(pc_i, h, tk, pp);
        end
        check({name, " model taken"}, 64'(pred_taken), 64'(tk));
        check({name, " model pc"}, pred_pc, pp);
        if (chk) begin
            check({name, " taken"}, 64'(pred_taken), 64'(etk));
            check({name, " pc"}, pred_pc, epc);
        end
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    task automatic look(input string name, input logic [63:0] pc, input bit ff,
                        input bit etk, input logic [63:0] epc);
        set_in(pc, ff, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
        cycle(name, 1'b1, etk, epc);
    endtask

    task automatic train(input logic [63:0] upc, input logic [1:0] ut, input bit utk,
                         input logic [63:0] utgt);
        set_in(64'h0, 1'b0, 1'b1, upc, ut, utk, utgt, 1'b0);
        cycle("train", 1'b0, 1'b0, 64'h0);
    endtask

    function automatic logic [63:0] pick_pc();
        int k;
        k = $urandom_range(0, 23);
        if (k < 16) return 64'h8000_0000 + 64'(k * 4);
        return 64'h8001_0000 + 64'(k * 4 - 64);
    endfunction

    initial begin
        logic [63:0] tg;
        model_reset();
        rst = 1'b1;
        set_in(64'h8000_0000, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);

        // Reset outputs while rst is held
        #1;
        check("t1 rst taken", 64'(pred_taken), 64'h0);
        check("t1 rst pc", pred_pc, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        look("t1 idle", 64'h8000_0000, 1'b0, 1'b0, 64'h8000_0004);

        // Conditional branch training and counter saturation
        set_in(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0010, 2'b00, 1'b1, 64'h8000_0100, 1'b0);
        cycle("t2 same-cycle", 1'b1, 1'b0, 64'h8000_0014);
        look("t2 hit", 64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        train(64'h8000_0010, 2'b00, 1'b0, 64'h0);
        look("t2 ctr01", 64'h8000_0010, 1'b0, 1'b0, 64'h8000_0014);
        train(64'h8000_0010, 2'b00, 1'b0, 64'h0);
        look("t2 ctr00", 64'h8000_0010, 1'b0, 1'b0, 64'h8000_0014);
        for (int k = 0; k < 4; k++) train(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0100);
        look("t2 ctr11", 64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        train(64'h8000_0010, 2'b00, 1'b0, 64'h0);
        look("t2 sat", 64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);

        // Call / return through the RAS
        train(64'h8000_0020, 2'b10, 1'b0, 64'h8000_0400);
        train(64'h8000_0404, 2'b11, 1'b0, 64'h8000_0800);
        look("t3 call", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
        look("t3 ret", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_0024);
        look("t3 ret empty", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_0800);
        look("t3 call nofire", 64'h8000_0020, 1'b0, 1'b1, 64'h8000_0400);
        look("t3 ret nopush", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_0800);

        // Nine nested calls overflow an eight-deep stack
        for (int k = 0; k < 9; k++)
            train(64'h8000_2000 + 64'(k * 8), 2'b10, 1'b1, 64'h8000_5000 + 64'(k * 256));
        for (int k = 0; k < 9; k++)
            look("t4 call", 64'h8000_2000 + 64'(k * 8), 1'b1, 1'b1, 64'h8000_5000 + 64'(k * 256));
        for (int k = 8; k >= 1; k--)
            look("t4 pop", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_2004 + 64'(k * 8));
        look("t4 pop empty", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_0800);

        // Aliasing on a shared index
        train(64'h8000_0010, 2'b00, 1'b1, 64'h8000_0100);
        look("t5 first", 64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100);
        train(64'h8001_0010, 2'b00, 1'b1, 64'h8000_0200);
        look("t5 evicted", 64'h8000_0010, 1'b0, 1'b0, 64'h8000_0014);
        look("t5 second", 64'h8001_0010, 1'b0, 1'b1, 64'h8000_0200);
        train(64'h8000_0010, 2'b00, 1'b0, 64'h8000_0900);
        look("t5 nt miss keep", 64'h8001_0010, 1'b0, 1'b1, 64'h8000_0200);
        look("t5 nt miss noalloc", 64'h8000_0010, 1'b0, 1'b0, 64'h8000_0014);

        // Clear beats a same-cycle update and empties the RAS
        train(64'h8000_0020, 2'b10, 1'b1, 64'h8000_0400);
        look("t6 push", 64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
        set_in(64'h8001_0010, 1'b1, 1'b1, 64'h8000_0040, 2'b01, 1'b1, 64'h8000_0300, 1'b1);
        cycle("t6 clr cycle", 1'b1, 1'b1, 64'h8000_0200);
        look("t6 clr miss a", 64'h8001_0010, 1'b0, 1'b0, 64'h8001_0014);
        look("t6 clr drop upd", 64'h8000_0040, 1'b0, 1'b0, 64'h8000_0044);
        look("t6 clr miss ret", 64'h8000_0404, 1'b0, 1'b0, 64'h8000_0408);
        train(64'h8000_0404, 2'b11, 1'b1, 64'h8000_0800);
        look("t6 ras emptied", 64'h8000_0404, 1'b1, 1'b1, 64'h8000_0800);

        // Asynchronous reset between clock edges
        train(64'h8000_0040, 2'b01, 1'b1, 64'h8000_0300);
        set_in(64'h8000_0040, 1'b0, 1'b0, 64'h0, 2'b00, 1'b0, 64'h0, 1'b0);
        #1;
        check("t6 pre-rst taken", 64'(pred_taken), 64'h1);
        check("t6 pre-rst pc", pred_pc, 64'h8000_0300);
        rst = 1'b1;
        #1;
        check("t6 async taken", 64'(pred_taken), 64'h0);
        check("t6 async pc", pred_pc, 64'h0);
        model_reset();
        rst = 1'b0;
        cycle("t6 post-rst", 1'b1, 1'b0, 64'h8000_0044);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            tg = {32'($urandom), 32'($urandom)};
            tg[0] = 1'b0;
            set_in(pick_pc(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_pc(),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? tg : pick_pc(),
                   ($urandom_range(0, 39) == 0));
            cycle("rand", 1'b0, 1'b0, 64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
